// File: rtl/output_display_driver.sv
// output_display_driver: sequential double-dabble of the output register driving a 4-digit multiplexed 7-segment display
module output_display_driver #(
  parameter int SCAN_DIV = 1024,
  parameter int DIV_W = 10
) (
  input logic clk,
  input logic rst,
  input logic [7:0] value,
  input logic signed_mode,
  output logic [6:0] seg,
  output logic [3:0] dig_sel,
  output logic busy,
  output logic [11:0] bcd_out,
  output logic neg
);
  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };
  state_t state, state_n;
  logic [8:0] shadow;
  logic [11:0] bcd, adj;
  logic [7:0] sh, mag;
  logic [2:0] iter;
  logic neg_pending, start;
  logic [DIV_W-1:0] presc;
  logic [3:0] nxt_sel, hund, tens, ones;
  logic [6:0] nxt_seg;
  assign start = state == IDLE && {signed_mode, value} != shadow;
  assign mag = (signed_mode && value[7]) ? ~value + 8'd1 : value;
  for (genvar g = 0; g < 3; g++) begin : g_adj
    assign adj[4*g +: 4] = bcd[4*g +: 4] >= 4'd5 ? bcd[4*g +: 4] + 4'd3 : bcd[4*g +: 4];
  end
  always_comb begin
    state_n = start ? CONVERT :
              (state == CONVERT && iter == 3'd7) ? UPDATE :
              state == UPDATE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shadow <= '0;
      bcd <= '0;
      sh <= '0;
      iter <= '0;
      neg_pending <= 1'b0;
      busy <= 1'b0;
      bcd_out <= '0;
      neg <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        shadow <= {signed_mode, value};
        sh <= mag;
        bcd <= '0;
        iter <= '0;
        neg_pending <= signed_mode & value[7];
        busy <= 1'b1;
      end
      if (state == CONVERT) begin
        {bcd, sh} <= {adj, sh} << 1;
        iter <= iter + 3'd1;
      end
      if (state == UPDATE) begin
        bcd_out <= bcd;
        neg <= neg_pending;
        busy <= 1'b0;
      end
    end
  end
  assign nxt_sel = {dig_sel[2:0], dig_sel[3]};
  assign {hund, tens, ones} = bcd_out;
  always_comb begin
    nxt_seg = nxt_sel[3] ? (neg ? 7'h40 : 7'h00) :
              nxt_sel[2] ? (hund == 4'd0 ? 7'h00 : SEG_LUT[hund]) :
              nxt_sel[1] ? ((hund == 4'd0 && tens == 4'd0) ? 7'h00 : SEG_LUT[tens]) :
              SEG_LUT[ones];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      dig_sel <= 4'b0001;
      seg <= 7'h3F;
    end else if (presc == DIV_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      dig_sel <= nxt_sel;
      seg <= nxt_seg;
    end else begin
      presc <= presc + DIV_W'(1);
    end
  end
endmodule

// File: tb/tb_output_display_driver.sv
// tb_output_display_driver: scoreboard bench for conversion results, latency, blanking and digit scan
module tb_output_display_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed_mode = 1'b0;
  logic [7:0] value = 8'h00;
  logic [6:0] seg;
  logic [3:0] dig_sel;
  logic busy;
  logic [11:0] bcd_out;
  logic neg;
  int n = 0;
  int errs = 0;
  logic [12:0] q[$];
  logic pb = 1'b0;
  int bc = 0;
  always #5 clk = ~clk;
  output_display_driver #(.SCAN_DIV(4), .DIV_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .signed_mode(signed_mode),
    .seg(seg),
    .dig_sel(dig_sel),
    .busy(busy),
    .bcd_out(bcd_out),
    .neg(neg)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail_to(input string name);
    n++;
    errs++;
    $display("FAIL %s: got timeout expected event", name);
  endtask
  always @(posedge clk) begin
    #1;
    if (rst) begin
      pb = 1'b0;
      bc = 0;
    end else begin
      if (busy) bc++;
      if (pb && !busy) begin
        if (q.size() == 0) begin
          n++;
          errs++;
          $display("FAIL commit: got %0h expected no commit", {neg, bcd_out});
        end else begin
          chk("commit", {neg, bcd_out}, q.pop_front());
          chk("busy_width", bc, 9);
        end
        bc = 0;
      end
      pb = busy;
    end
  end
  task automatic wait_conv();
    int t = 0;
    while (!busy && t < 5) begin
      @(negedge clk);
      t++;
    end
    if (!busy) begin
      fail_to("busy_rise");
      return;
    end
    t = 0;
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (busy) fail_to("busy_fall");
  endtask
  task automatic conv(input logic sm, input logic [7:0] v, input logic [12:0] e);
    signed_mode = sm;
    value = v;
    q.push_back(e);
    @(negedge clk);
    wait_conv();
  endtask
  task automatic chk_scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] e[4];
    int t = 0;
    e = '{s0, s1, s2, s3};
    while (dig_sel !== 4'b1000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    while (dig_sel !== 4'b0001 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (dig_sel !== 4'b0001) begin
      fail_to("scan_sync");
      return;
    end
    for (int i = 0; i < 16; i++) begin
      chk("scan", {dig_sel, seg}, {4'(1 << (i / 4)), e[i / 4]});
      @(negedge clk);
    end
    chk("scan_wrap", dig_sel, 4'b0001);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_bcd", {neg, bcd_out}, 0);
    chk("rst_dig", dig_sel, 4'b0001);
    chk("rst_seg", seg, 7'h3F);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk_scan(7'h3F, 7'h00, 7'h00, 7'h00);
    chk("idle_busy2", busy, 0);
    conv(1'b0, 8'hFF, 13'h0255);
    chk_scan(7'h6D, 7'h6D, 7'h5B, 7'h00);
    conv(1'b1, 8'hFF, 13'h1001);
    chk_scan(7'h06, 7'h00, 7'h00, 7'h40);
    conv(1'b1, 8'h80, 13'h1128);
    chk_scan(7'h7F, 7'h5B, 7'h06, 7'h40);
    conv(1'b1, 8'h7F, 13'h0127);
    chk_scan(7'h07, 7'h5B, 7'h06, 7'h00);
    signed_mode = 1'b0;
    value = 8'h0C;
    q.push_back(13'h0012);
    q.push_back(13'h0200);
    repeat (3) @(negedge clk);
    value = 8'hC8;
    wait_conv();
    chk("overlap_first", bcd_out, 12'h012);
    wait_conv();
    chk_scan(7'h3F, 7'h3F, 7'h5B, 7'h00);
    conv(1'b0, 8'h05, 13'h0005);
    chk_scan(7'h6D, 7'h00, 7'h00, 7'h00);
    value = 8'hFF;
    begin
      int t = 0;
      while (!busy && t < 5) begin
        @(negedge clk);
        t++;
      end
    end
    if (!busy) fail_to("abort_rise");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_bcd", {neg, bcd_out}, 0);
    chk("abort_dig", dig_sel, 4'b0001);
    chk("abort_seg", seg, 7'h3F);
    rst = 1'b0;
    q.push_back(13'h0255);
    @(negedge clk);
    wait_conv();
    chk_scan(7'h6D, 7'h6D, 7'h5B, 7'h00);
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
